bsg_mem_1r1w_sync_mask_write_byte_arb: RTL and testbench

//   Shares one 1r1w synchronous byte-masked-write memory among num_clients_p requesters.

---
 rtl/bsg_mem_1r1w_sync_mask_write_byte_arb.sv | 147 ++++++++++++++
 tb/tb_bsg_mem_1r1w_sync_mask_write_byte_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1r1w_sync_mask_write_byte_arb.sv
// Round-robin front end that shares one 1r1w byte-masked synchronous memory among
// several clients; read and write ports are arbitrated independently.
module bsg_mem_1r1w_sync_mask_write_byte_arb #(
    parameter int width_p       = 32,
    parameter int els_p         = 1024,
    parameter int num_clients_p = 2,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    parameter int mask_width_lp = width_p >> 3
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_clients_p-1:0]               v_i,
    input  logic [num_clients_p-1:0]               w_i,
    input  logic [num_clients_p*addr_width_lp-1:0] addr_i,
    input  logic [num_clients_p*width_p-1:0]       data_i,
    input  logic [num_clients_p*mask_width_lp-1:0] mask_i,
    output logic [num_clients_p-1:0]               ready_o,
    output logic [num_clients_p-1:0]               v_o,
    output logic [num_clients_p*width_p-1:0]       data_o,
    input  logic [num_clients_p-1:0]               yumi_i,
    output logic                                   mem_r_v_o,
    output logic [addr_width_lp-1:0]               mem_r_addr_o,
    output logic                                   mem_w_v_o,
    output logic [addr_width_lp-1:0]               mem_w_addr_o,
    output logic [width_p-1:0]                     mem_w_data_o,
    output logic [mask_width_lp-1:0]               mem_w_mask_o,
    input  logic [width_p-1:0]                     mem_data_i
);
    localparam int id_width_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;

    logic [num_clients_p-1:0] pend_reg, pend_next;
    logic [num_clients_p-1:0] resp_v_reg, resp_v_next;
    logic [width_p-1:0]       resp_data_reg [num_clients_p];
    logic                     rd_inflight_reg;
    logic [id_width_lp-1:0]   rd_owner_reg;
    logic [id_width_lp-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [id_width_lp-1:0]   wr_ptr_reg, wr_ptr_next;

    logic [num_clients_p-1:0] rd_elig, wr_elig, rd_gnt, wr_gnt;
    logic                     rd_found, wr_found, rd_any, wr_any;
    logic [id_width_lp-1:0]   rd_id, wr_id;

    logic [addr_width_lp-1:0] addr_arr [num_clients_p];
    logic [width_p-1:0]       data_arr [num_clients_p];
    logic [mask_width_lp-1:0] mask_arr [num_clients_p];

    // Returns {found, id}: first requester at or after start, wrapping around.
    function automatic logic [id_width_lp:0] rr_pick(input logic [num_clients_p-1:0] req,
                                                     input logic [id_width_lp-1:0]   start);
        logic                   found;
        logic [id_width_lp-1:0] id;
        logic [id_width_lp-1:0] idx;
        logic [id_width_lp:0]   sum;
        found = 1'b0;
        id    = '0;
        for (int i = 0; i < num_clients_p; i++) begin
            sum = {1'b0, start} + (id_width_lp+1)'(i);
            if (sum >= (id_width_lp+1)'(num_clients_p))
                sum = sum - (id_width_lp+1)'(num_clients_p);
            idx = sum[id_width_lp-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
        return {found, id};
    endfunction

    for (genvar gi = 0; gi < num_clients_p; gi++) begin : g_client
        assign addr_arr[gi] = addr_i[gi*addr_width_lp +: addr_width_lp];
        assign data_arr[gi] = data_i[gi*width_p +: width_p];
        assign mask_arr[gi] = mask_i[gi*mask_width_lp +: mask_width_lp];

        // A held response blocks a new read unless it is being consumed this cycle.
        assign rd_elig[gi] = v_i[gi] & ~w_i[gi] & ~pend_reg[gi] & (~resp_v_reg[gi] | yumi_i[gi]);
        assign wr_elig[gi] = v_i[gi] & w_i[gi];

        assign rd_gnt[gi]  = rd_any & (rd_id == id_width_lp'(gi));
        assign wr_gnt[gi]  = wr_any & (wr_id == id_width_lp'(gi));

        assign data_o[gi*width_p +: width_p] = resp_data_reg[gi];
    end

    assign {rd_found, rd_id} = rr_pick(rd_elig, rd_ptr_reg);
    assign {wr_found, wr_id} = rr_pick(wr_elig, wr_ptr_reg);
    assign rd_any = reset_n_i & rd_found;
    assign wr_any = reset_n_i & wr_found;

    assign ready_o      = rd_gnt | wr_gnt;
    assign v_o          = resp_v_reg & {num_clients_p{reset_n_i}};

    assign mem_r_v_o    = rd_any;
    assign mem_r_addr_o = addr_arr[rd_id];
    assign mem_w_v_o    = wr_any;
    assign mem_w_addr_o = addr_arr[wr_id];
    assign mem_w_data_o = data_arr[wr_id];
    assign mem_w_mask_o = mask_arr[wr_id];

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (rd_any)
            rd_ptr_next = (rd_id == id_width_lp'(num_clients_p-1)) ? '0 : rd_id + 1'b1;
        if (wr_any)
            wr_ptr_next = (wr_id == id_width_lp'(num_clients_p-1)) ? '0 : wr_id + 1'b1;
    end

    always_comb begin
        pend_next   = pend_reg;
        resp_v_next = resp_v_reg & ~yumi_i;
        if (rd_inflight_reg) begin
            pend_next[rd_owner_reg]   = 1'b0;
            resp_v_next[rd_owner_reg] = 1'b1;
        end
        pend_next = pend_next | rd_gnt;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pend_reg        <= '0;
            resp_v_reg      <= '0;
            rd_inflight_reg <= 1'b0;
            rd_owner_reg    <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            pend_reg        <= pend_next;
            resp_v_reg      <= resp_v_next;
            rd_inflight_reg <= rd_any;
            rd_owner_reg    <= rd_id;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    // Memory read data is valid one cycle after the grant; capture it for the owner.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < num_clients_p; c++) begin
            if (reset_n_i && rd_inflight_reg && rd_owner_reg == id_width_lp'(c))
                resp_data_reg[c] <= mem_data_i;
        end
    end

    a_yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ~|(yumi_i & ~v_o));

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_byte_arb.sv
// Randomized and directed bench for the shared-memory arbiter, checked every cycle
// against a request-level model of grants, memory contents and responses.
module tb_bsg_mem_1r1w_sync_mask_write_byte_arb;
    localparam int W   = 32;
    localparam int ELS = 1024;
    localparam int N   = 2;
    localparam int AW  = 10;
    localparam int MW  = W >> 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  v = '0, w = '0, yumi = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*W-1:0]  data = '0;
    logic [N*MW-1:0] mask = '0;
    logic [N-1:0]  ready, v_o;
    logic [N*W-1:0] data_o;
    logic          mem_r_v, mem_w_v;
    logic [AW-1:0] mem_r_addr, mem_w_addr;
    logic [W-1:0]  mem_w_data, mem_data;
    logic [MW-1:0] mem_w_mask;

    bsg_mem_1r1w_sync_mask_write_byte_arb #(.width_p(W), .els_p(ELS), .num_clients_p(N)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .w_i(w), .addr_i(addr), .data_i(data),
        .mask_i(mask), .ready_o(ready), .v_o(v_o), .data_o(data_o), .yumi_i(yumi),
        .mem_r_v_o(mem_r_v), .mem_r_addr_o(mem_r_addr), .mem_w_v_o(mem_w_v),
        .mem_w_addr_o(mem_w_addr), .mem_w_data_o(mem_w_data), .mem_w_mask_o(mem_w_mask),
        .mem_data_i(mem_data));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] merge(logic [W-1:0] old_w, logic [W-1:0] new_w, logic [MW-1:0] m);
        logic [W-1:0] r;
        r = old_w;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // Write-first synchronous memory standing in for the macro.
    logic [W-1:0] envm [ELS];
    always @(posedge clk) begin
        if (mem_r_v)
            mem_data <= (mem_w_v && mem_w_addr == mem_r_addr) ?
                        merge(envm[mem_r_addr], mem_w_data, mem_w_mask) : envm[mem_r_addr];
        if (mem_w_v)
            envm[mem_w_addr] <= merge(envm[mem_w_addr], mem_w_data, mem_w_mask);
    end

    // Reference model state: memory image, per-client outstanding read, priority starts.
    logic [W-1:0] gold [ELS];
    bit           busy [N];
    int           rdy_cyc [N];
    logic [W-1:0] exp_d [N];
    int           rd_next = 0, wr_next = 0, cyc = 0;
    int           rd_gnt_cnt [N];
    int           checks = 0, errors = 0;
    logic [N-1:0] yumi_en = '1;

    initial begin
        for (int i = 0; i < ELS; i++) begin envm[i] = '0; gold[i] = '0; end
        for (int c = 0; c < N; c++) begin busy[c] = 0; rdy_cyc[c] = 0; exp_d[c] = '0; rd_gnt_cnt[c] = 0; end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(logic [N-1:0] req, int start);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (start + i) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] relig, welig, exp_rdy, exp_vo;
        int rg, wg;
        logic [AW-1:0] a;
        for (int c = 0; c < N; c++) exp_vo[c] = busy[c] && (cyc >= rdy_cyc[c]);
        if (!reset_n) begin
            chk("rst_ready", ready, 0);
            chk("rst_v_o", v_o, 0);
            chk("rst_mem_r_v", mem_r_v, 0);
            chk("rst_mem_w_v", mem_w_v, 0);
            for (int c = 0; c < N; c++) busy[c] = 0;
            rd_next = 0;
            wr_next = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                relig[c] = v[c] & ~w[c] & (!busy[c] || (exp_vo[c] && yumi[c]));
                welig[c] = v[c] & w[c];
            end
            rg = pick(relig, rd_next);
            wg = pick(welig, wr_next);
            exp_rdy = '0;
            if (rg >= 0) exp_rdy[rg] = 1'b1;
            if (wg >= 0) exp_rdy[wg] = 1'b1;
            chk("ready", ready, exp_rdy);
            chk("v_o", v_o, exp_vo);
            for (int c = 0; c < N; c++)
                if (exp_vo[c]) chk($sformatf("data_o%0d", c), data_o[c*W +: W], exp_d[c]);
            chk("mem_r_v", mem_r_v, rg >= 0);
            chk("mem_w_v", mem_w_v, wg >= 0);
            if (wg >= 0) begin
                a = addr[wg*AW +: AW];
                chk("mem_w_addr", mem_w_addr, a);
                chk("mem_w_data", mem_w_data, data[wg*W +: W]);
                chk("mem_w_mask", mem_w_mask, mask[wg*MW +: MW]);
                gold[a] = merge(gold[a], data[wg*W +: W], mask[wg*MW +: MW]);
                wr_next = (wg + 1) % N;
            end
            for (int c = 0; c < N; c++) if (exp_vo[c] && yumi[c]) busy[c] = 0;
            if (rg >= 0) begin
                a = addr[rg*AW +: AW];
                chk("mem_r_addr", mem_r_addr, a);
                busy[rg]    = 1;
                rdy_cyc[rg] = cyc + 2;
                exp_d[rg]   = gold[a];
                rd_next     = (rg + 1) % N;
                rd_gnt_cnt[rg]++;
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // Consume responses only while they are valid, as the protocol requires.
    initial forever begin
        @(posedge clk);
        #1;
        yumi = v_o & yumi_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int c, bit vv, bit ww, logic [AW-1:0] a, logic [W-1:0] d, logic [MW-1:0] m);
        v[c] = vv;
        w[c] = ww;
        addr[c*AW +: AW] = a;
        data[c*W +: W]   = d;
        mask[c*MW +: MW] = m;
    endtask

    task automatic wait_accept(int c, string name);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ready[c];
            tick();
        end
        chk({name, "_accept"}, got, 1);
    endtask

    task automatic do_write(int c, logic [AW-1:0] a, logic [W-1:0] d, logic [MW-1:0] m);
        set_req(c, 1, 1, a, d, m);
        wait_accept(c, "wr");
        v[c] = 0;
    endtask

    task automatic do_read(int c, logic [AW-1:0] a, output logic [W-1:0] d);
        set_req(c, 1, 0, a, '0, '0);
        wait_accept(c, "rd");
        v[c] = 0;
        chk("lat_t1_v_o", v_o[c], 0);
        tick();
        chk("lat_t2_v_o", v_o[c], 1);
        d = data_o[c*W +: W];
    endtask

    initial begin
        logic [W-1:0] d, d0;
        int c0s, c1s;
        repeat (3) tick();
        reset_n = 1;
        repeat (2) tick();

        // Write then read back; partial-mask overwrite.
        do_write(0, 5, 32'hDEADBEEF, 4'hF);
        do_read(0, 5, d);
        $display("T1 read addr5 data=%h", d);
        chk("t1_data", d, 32'hDEADBEEF);
        repeat (2) tick();
        do_write(0, 5, 32'h11223344, 4'b0101);
        do_read(0, 5, d);
        $display("T2 read addr5 data=%h", d);
        chk("t2_data", d, 32'hDE22BE44);
        repeat (3) tick();

        // Both clients read continuously: strict alternation.
        c0s = rd_gnt_cnt[0];
        c1s = rd_gnt_cnt[1];
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1, 0, AW'($urandom_range(0, 15)), '0, '0);
            set_req(1, 1, 0, AW'($urandom_range(0, 15)), '0, '0);
            tick();
        end
        $display("T3 grants c0=%0d c1=%0d", rd_gnt_cnt[0] - c0s, rd_gnt_cnt[1] - c1s);
        chk("t3_c0_grants", rd_gnt_cnt[0] - c0s, 10);
        chk("t3_c1_grants", rd_gnt_cnt[1] - c1s, 10);

        // Client0 stalls its response; client1 keeps reading every other cycle.
        yumi_en = 2'b10;
        repeat (6) tick();
        d0  = data_o[W-1:0];
        c0s = rd_gnt_cnt[0];
        c1s = rd_gnt_cnt[1];
        for (int i = 0; i < 10; i++) begin
            set_req(1, 1, 0, AW'($urandom_range(0, 15)), '0, '0);
            tick();
            chk("t4_hold_data0", data_o[W-1:0], d0);
        end
        $display("T4 grants c0=%0d c1=%0d", rd_gnt_cnt[0] - c0s, rd_gnt_cnt[1] - c1s);
        chk("t4_c0_grants", rd_gnt_cnt[0] - c0s, 0);
        chk("t4_c1_grants", rd_gnt_cnt[1] - c1s, 5);
        chk("t4_v_o0", v_o[0], 1);
        v = '0;
        yumi_en = '1;
        repeat (4) tick();

        // Same-cycle write and read to one address.
        set_req(0, 1, 1, 9, 32'hA5A5A5A5, 4'hF);
        set_req(1, 1, 0, 9, '0, '0);
        @(negedge clk);
        chk("t5_ready", ready, 2'b11);
        tick();
        v = '0;
        tick();
        chk("t5_v_o1", v_o[1], 1);
        $display("T5 client1 read addr9 data=%h", data_o[W +: W]);
        chk("t5_data", data_o[W +: W], 32'hA5A5A5A5);
        repeat (3) tick();

        // Reset the cycle after a read grant.
        set_req(0, 1, 0, 5, '0, '0);
        @(negedge clk);
        chk("t6_grant", ready[0], 1);
        tick();
        v = '0;
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_v_o", v_o, 0);
        end
        set_req(0, 1, 0, 1, '0, '0);
        set_req(1, 1, 0, 2, '0, '0);
        @(negedge clk);
        $display("T6 post-reset ready=%b", ready);
        chk("t6_first_grant", ready, 2'b01);
        tick();
        v = '0;
        repeat (4) tick();

        // Randomized traffic with address collisions.
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++)
                set_req(c, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                        AW'($urandom_range(0, 15)), $urandom, MW'($urandom_range(0, 15)));
            yumi_en = N'($urandom);
            tick();
        end
        v = '0;
        yumi_en = '1;
        repeat (5) tick();
        $display("random phase done, read grants c0=%0d c1=%0d", rd_gnt_cnt[0], rd_gnt_cnt[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
